// File: rtl/flash_pkg.sv
// Shared types for the flash return path: route-select encoding, controller
// states and the default transfer length.
package flash_pkg;

  localparam int PAGE_BYTES_DEF = 16;

  typedef enum logic [1:0] {
    OPB_NONE = 2'b00,
    OPB_SRAM = 2'b01,
    OPB_FIFO = 2'b10,
    OPB_STAT = 2'b11
  } opb_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRAM,
    ST_FIFO,
    ST_STAT,
    ST_DONE
  } opb_state_e;

endpackage

// File: rtl/output_process_block_if.sv
// Bus bundle between the FCU/flash side (master) and the output process block (slave).
interface output_process_block_if
  import flash_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic [7:0]        FDataOut;
  opb_cmd_e          OPBCommand;
  logic              start;
  logic              output_shift;
  logic [ADDR_W-1:0] SRAM_Addr_base;
  logic              FIFO_full;

  logic [7:0]        In_SRAM;
  logic [ADDR_W-1:0] SRAM_Addr;
  logic              SRAM_wen;
  logic [7:0]        FIFO_data;
  logic              FIFO_wen;
  logic [7:0]        Status;
  logic              busy;
  logic              stall;
  logic              overrun;
  logic              done;

  modport master (
    output FDataOut, OPBCommand, start, output_shift, SRAM_Addr_base, FIFO_full,
    input  In_SRAM, SRAM_Addr, SRAM_wen, FIFO_data, FIFO_wen, Status,
    input  busy, stall, overrun, done
  );

  modport slave (
    input  FDataOut, OPBCommand, start, output_shift, SRAM_Addr_base, FIFO_full,
    output In_SRAM, SRAM_Addr, SRAM_wen, FIFO_data, FIFO_wen, Status,
    output busy, stall, overrun, done
  );
endinterface

// File: rtl/opb_hold_buffer.sv
// Single-entry skid register in front of the host output FIFO; reports
// back-pressure and latches a sticky overrun when a byte arrives while blocked.
module opb_hold_buffer (
  input  logic       clk2,
  input  logic       NReset,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       fifo_full_i,
  input  logic       drop_i,
  input  logic       clear_i,
  output logic [7:0] data_o,
  output logic       fifo_wen_o,
  output logic       stall_o,
  output logic       overrun_o
);

  logic       hold_valid_q;
  logic [7:0] hold_data_q;
  logic       overrun_q;

  assign fifo_wen_o = hold_valid_q & ~fifo_full_i;
  assign stall_o    = hold_valid_q & fifo_full_i;
  assign data_o     = hold_data_q;
  assign overrun_o  = overrun_q;

  // A load in the same cycle as a drain keeps the entry occupied with the new byte.
  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'h00;
      overrun_q    <= 1'b0;
    end else begin
      if (load_i) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= data_i;
      end else if (fifo_wen_o) begin
        hold_valid_q <= 1'b0;
      end
      if (clear_i) begin
        overrun_q <= 1'b0;
      end else if (drop_i) begin
        overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_process_block.sv
// Flash return-path router: captures FDataOut on FCU strobes and steers each
// byte to SRAM, the host output FIFO or the status register.
//
// state   | meaning
// IDLE    | waiting for an FCU start with a non-zero route
// SRAM    | page read, one SRAM write per strobe at base+k
// FIFO    | page read through the hold buffer into the host FIFO
// STAT    | waiting for the single status byte
// DONE    | one-cycle completion pulse, then back to IDLE
module output_process_block
  import flash_pkg::*;
#(
  parameter int PAGE_BYTES = PAGE_BYTES_DEF,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk2,
  input  logic                  NReset,
  output_process_block_if.slave bus
);

  localparam int               CNT_W    = $clog2(PAGE_BYTES + 1);
  localparam logic [CNT_W-1:0] PAGE_CNT = CNT_W'(PAGE_BYTES);

  opb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [7:0]        in_sram_q;
  logic [7:0]        status_q;
  logic              sram_wen_q;
  logic              busy_q;
  logic              done_q;

  logic start_ok;
  logic room;
  logic sram_cap;
  logic fifo_cap;
  logic fifo_drop;
  logic fifo_wen;
  logic stall;

  assign start_ok  = bus.start && (state_q == ST_IDLE) && (bus.OPBCommand != OPB_NONE);
  assign room      = (cnt_q != PAGE_CNT);
  assign sram_cap  = (state_q == ST_SRAM) && bus.output_shift && room;
  assign fifo_cap  = (state_q == ST_FIFO) && bus.output_shift && !stall && room;
  assign fifo_drop = (state_q == ST_FIFO) && bus.output_shift && stall;

  opb_hold_buffer u_hold (
    .clk2        (clk2),
    .NReset      (NReset),
    .load_i      (fifo_cap),
    .data_i      (bus.FDataOut),
    .fifo_full_i (bus.FIFO_full),
    .drop_i      (fifo_drop),
    .clear_i     (start_ok),
    .data_o      (bus.FIFO_data),
    .fifo_wen_o  (fifo_wen),
    .stall_o     (stall),
    .overrun_o   (bus.overrun)
  );

  always_ff @(posedge clk2 or negedge NReset) begin
    if (!NReset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      sram_addr_q <= '0;
      in_sram_q   <= 8'h00;
      status_q    <= 8'h00;
      sram_wen_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sram_wen_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            cnt_q  <= '0;
            addr_q <= bus.SRAM_Addr_base;
            busy_q <= 1'b1;
            case (bus.OPBCommand)
              OPB_SRAM: state_q <= ST_SRAM;
              OPB_FIFO: state_q <= ST_FIFO;
              default:  state_q <= ST_STAT;
            endcase
          end
        end
        ST_SRAM: begin
          if (sram_cap) begin
            sram_wen_q  <= 1'b1;
            in_sram_q   <= bus.FDataOut;
            sram_addr_q <= addr_q;
            addr_q      <= addr_q + ADDR_W'(1);
            cnt_q       <= cnt_q + CNT_W'(1);
          end
          // Finish only once the last byte's write cycle is on the bus.
          if (sram_wen_q && !room) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_FIFO: begin
          if (fifo_cap) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (fifo_wen && !room) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_STAT: begin
          if (bus.output_shift) begin
            status_q <= bus.FDataOut;
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.In_SRAM   = in_sram_q;
  assign bus.SRAM_Addr = sram_addr_q;
  assign bus.SRAM_wen  = sram_wen_q;
  assign bus.Status    = status_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.FIFO_wen  = fifo_wen;
  assign bus.stall     = stall;

endmodule

// File: tb/tb_output_process_block.sv
// Randomised bench for output_process_block: transaction-level expectations
// for SRAM pages, FIFO pages with back-pressure, status reads and resets.
module tb_output_process_block;
  import flash_pkg::*;

  localparam int PAGE = 16;

  logic clk2 = 1'b0;
  logic NReset;

  output_process_block_if #(.ADDR_W(8)) bus ();

  output_process_block #(.PAGE_BYTES(PAGE), .ADDR_W(8)) dut (
    .clk2   (clk2),
    .NReset (NReset),
    .bus    (bus)
  );

  always #5 clk2 = ~clk2;

  int cyc = 0;
  always @(posedge clk2) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int         c;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t mon_sram[$];
  int  mon_done[$];
  int  mon_fifo_n = 0;
  int  last_busy  = 0;

  always begin
    @(negedge clk2);
    #2;
    if (bus.SRAM_wen === 1'b1) mon_sram.push_back('{cyc, bus.SRAM_Addr, bus.In_SRAM});
    if (bus.FIFO_wen === 1'b1) mon_fifo_n++;
    if (bus.done === 1'b1) mon_done.push_back(cyc);
    if (bus.busy === 1'b1) last_busy = cyc;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle();
    bus.start        = 1'b0;
    bus.output_shift = 1'b0;
    bus.OPBCommand   = OPB_NONE;
    bus.FIFO_full    = 1'b0;
  endtask

  task automatic clear_mon();
    mon_sram.delete();
    mon_done.delete();
    mon_fifo_n = 0;
  endtask

  task automatic check_zero(input string t);
    chk({t, "_sram_wen"},  bus.SRAM_wen,  0);
    chk({t, "_in_sram"},   bus.In_SRAM,   0);
    chk({t, "_sram_addr"}, bus.SRAM_Addr, 0);
    chk({t, "_fifo_wen"},  bus.FIFO_wen,  0);
    chk({t, "_fifo_data"}, bus.FIFO_data, 0);
    chk({t, "_status"},    bus.Status,    0);
    chk({t, "_busy"},      bus.busy,      0);
    chk({t, "_stall"},     bus.stall,     0);
    chk({t, "_overrun"},   bus.overrun,   0);
    chk({t, "_done"},      bus.done,      0);
  endtask

  task automatic do_start(input opb_cmd_e c, input logic [7:0] b);
    @(negedge clk2);
    idle();
    bus.start          = 1'b1;
    bus.OPBCommand     = c;
    bus.SRAM_Addr_base = b;
    #2 chk("busy_at_start", bus.busy, 0);
    @(negedge clk2);
    idle();
    #2 chk("busy_after_start", bus.busy, 1);
    chk("overrun_cleared", bus.overrun, 0);
  endtask

  task automatic run_ignored();
    clear_mon();
    @(negedge clk2);
    idle();
    bus.start          = 1'b1;
    bus.OPBCommand     = OPB_NONE;
    bus.SRAM_Addr_base = 8'h55;
    repeat (3) begin
      @(negedge clk2);
      idle();
      bus.output_shift = 1'b1;
      #2 chk("none_busy", bus.busy, 0);
    end
    @(negedge clk2);
    idle();
    #3;
    chk("none_done", mon_done.size(), 0);
    chk("none_writes", mon_sram.size() + mon_fifo_n, 0);
  endtask

  task automatic run_sram(input logic [7:0] base, input bit dense, input bit inc,
                          input bit poke, input int abort_after);
    logic [7:0] d [PAGE];
    int         sc [PAGE];
    int         n;
    int         last;
    logic [7:0] ea;
    clear_mon();
    do_start(OPB_SRAM, base);
    n = (abort_after >= 0) ? abort_after + 1 : PAGE;
    for (int k = 0; k < n; k++) begin
      if (!dense) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk2);
          idle();
        end
      end
      @(negedge clk2);
      idle();
      d[k]  = inc ? 8'hA0 + 8'(k) : 8'($urandom);
      sc[k] = cyc;
      bus.output_shift = 1'b1;
      bus.FDataOut     = d[k];
      if (poke && k == 7) begin
        bus.start          = 1'b1;
        bus.OPBCommand     = OPB_FIFO;
        bus.SRAM_Addr_base = 8'h00;
      end
    end
    last = sc[n-1];
    if (abort_after >= 0) begin
      @(negedge clk2);
      idle();
      NReset = 1'b0;
      #2 check_zero("abort");
      repeat (3) begin
        @(negedge clk2);
        idle();
      end
      NReset = 1'b1;
      repeat (3) @(negedge clk2);
      #3;
      chk("abort_no_done", mon_done.size(), 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_writes", mon_sram.size(), abort_after);
      return;
    end
    repeat (4) begin
      @(negedge clk2);
      idle();
    end
    #3;
    chk("sram_nwr", mon_sram.size(), PAGE);
    for (int k = 0; k < mon_sram.size() && k < PAGE; k++) begin
      ea = base + 8'(k);
      chk("sram_addr", mon_sram[k].a, ea);
      chk("sram_data", mon_sram[k].d, d[k]);
      chk("sram_wr_cycle", mon_sram[k].c, sc[k] + 1);
    end
    chk("sram_ndone", mon_done.size(), 1);
    if (mon_done.size() > 0) chk("sram_done_cycle", mon_done[0], last + 2);
    chk("sram_busy_last", last_busy, last + 2);
    chk("sram_no_fifo", mon_fifo_n, 0);
  endtask

  task automatic run_fifo(input bit directed);
    int         captured = 0;
    int         written  = 0;
    int         rel      = 0;
    bit         pend     = 0;
    bit         ovr_e    = 0;
    bit         st_e;
    bit         wen_e;
    bit         sh;
    logic [7:0] pb       = 8'h00;
    clear_mon();
    do_start(OPB_FIFO, 8'($urandom));
    while (written < PAGE && rel < 600) begin
      @(negedge clk2);
      idle();
      bus.FIFO_full = directed ? (rel >= 3 && rel <= 5) : ($urandom_range(0, 3) == 0);
      st_e  = pend && bus.FIFO_full;
      wen_e = pend && !bus.FIFO_full;
      sh = (captured < PAGE) &&
           (directed ? (!st_e || rel == 4) : ($urandom_range(0, 2) != 0));
      bus.output_shift = sh;
      bus.FDataOut     = 8'($urandom);
      #2;
      chk("fifo_stall", bus.stall, st_e);
      chk("fifo_wen", bus.FIFO_wen, wen_e);
      if (wen_e) begin
        chk("fifo_data", bus.FIFO_data, pb);
        written++;
        pend = 0;
      end
      if (sh) begin
        if (st_e) begin
          ovr_e = 1;
        end else begin
          pend = 1;
          pb   = bus.FDataOut;
          captured++;
        end
      end
      rel++;
    end
    chk("fifo_written", written, PAGE);
    @(negedge clk2);
    idle();
    #2 chk("fifo_done", bus.done, 1);
    chk("fifo_overrun", bus.overrun, ovr_e);
    if (directed) chk("fifo_dir_overrun", bus.overrun, 1);
    @(negedge clk2);
    idle();
    #3;
    chk("fifo_idle", bus.busy, 0);
    chk("fifo_ndone", mon_done.size(), 1);
    chk("fifo_no_sram", mon_sram.size(), 0);
  endtask

  task automatic run_stat(input logic [7:0] v);
    clear_mon();
    do_start(OPB_STAT, 8'($urandom));
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk2);
      idle();
      #2 chk("stat_wait_busy", bus.busy, 1);
    end
    @(negedge clk2);
    idle();
    bus.output_shift = 1'b1;
    bus.FDataOut     = v;
    @(negedge clk2);
    idle();
    #2 chk("stat_value", bus.Status, v);
    chk("stat_done", bus.done, 1);
    @(negedge clk2);
    idle();
    #2 chk("stat_idle", bus.busy, 0);
    repeat (3) begin
      @(negedge clk2);
      idle();
      bus.output_shift = 1'b1;
      bus.FDataOut     = ~v;
    end
    @(negedge clk2);
    idle();
    #3;
    chk("stat_hold", bus.Status, v);
    chk("stat_ndone", mon_done.size(), 1);
    chk("stat_no_writes", mon_sram.size() + mon_fifo_n, 0);
  endtask

  initial begin
    NReset             = 1'b0;
    idle();
    bus.FDataOut       = 8'h00;
    bus.SRAM_Addr_base = 8'h00;
    repeat (2) @(negedge clk2);
    #2 check_zero("por");
    @(negedge clk2);
    NReset = 1'b1;

    run_ignored();
    run_sram(8'h10, 1, 1, 0, -1);
    run_sram(8'hF8, 1, 0, 0, -1);
    run_sram(8'h33, 0, 0, 1, -1);
    run_fifo(1);
    run_fifo(0);
    run_fifo(0);
    run_stat(8'hE0);
    run_stat(8'($urandom));
    run_sram(8'h40, 1, 0, 0, 5);
    run_sram(8'h10, 0, 0, 0, -1);
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0:       run_sram(8'($urandom), $urandom_range(0, 1) == 1, 0, 0, -1);
        1:       run_fifo(0);
        default: run_stat(8'($urandom));
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
